// File: rtl/tdc_enable_scheduler_pkg.sv
// Shared types for the TDC enable scheduler: FSM state encoding and the
// register-side mask width.
package TDCEnablePackage;

    localparam int MAX_CHANNELS = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DIS,
        EN,
        SETTLE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/tdc_enable_scheduler_lowest.sv
// Combinational priority encoder: index of the lowest set bit of i_vec.
// Zero latency; o_vld is low when no bit is set (o_idx is then 0).
module tdc_lowest_bit_finder #(
    parameter int WIDTH = 2,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        // Scan downwards so the last hit, the lowest index, wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_enable_scheduler.sv
// Fetches a new channel mask on request, retires dropped channels once idle,
// then raises new channels one at a time with a settle gap; all outputs registered.
module tdc_enable_scheduler
    import TDCEnablePackage::*;
#(
    parameter int CHANNEL_COUNT = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [MAX_CHANNELS-1:0]  activate_channels,
    input  logic                     channel_changed,
    input  logic                     read_ack,
    input  logic [CHANNEL_COUNT-1:0] channel_busy,
    output logic [CHANNEL_COUNT-1:0] enable_channels,
    output logic                     read_active_channel,
    output logic                     config_done,
    output logic                     sched_busy,
    output logic                     ack_timeout_err
);

    localparam int              TO_W        = $clog2(ACK_TIMEOUT + 1);
    localparam int              IDX_W       = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES);

    sched_state_t             r_state;
    sched_state_t             w_next;
    logic [CHANNEL_COUNT-1:0] r_target;
    logic [CHANNEL_COUNT-1:0] r_enable;
    logic                     r_pending;
    logic [7:0]               r_settle_cnt;
    logic [TO_W-1:0]          r_to_cnt;
    logic                     r_read_req;
    logic                     r_cfg_done;
    logic                     r_busy;
    logic                     r_to_err;

    logic [CHANNEL_COUNT-1:0] w_drop;
    logic [CHANNEL_COUNT-1:0] w_clear;
    logic [CHANNEL_COUNT-1:0] w_add;
    logic [CHANNEL_COUNT-1:0] w_onehot;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_pick_vld;
    logic                     w_ack_timeout;
    logic                     w_unused_hi;

    // Bits above CHANNEL_COUNT are never part of the target.
    assign w_unused_hi   = ^activate_channels;
    assign w_drop        = r_enable & ~r_target;
    assign w_clear       = w_drop & ~channel_busy;
    assign w_add         = r_target & ~r_enable;
    assign w_ack_timeout = (r_state == REQ) && !read_ack && (r_to_cnt == TO_LAST);

    tdc_lowest_bit_finder #(
        .WIDTH (CHANNEL_COUNT),
        .IDX_W (IDX_W)
    ) u_lowest (
        .i_vec (w_add),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    always_comb begin
        w_onehot             = '0;
        w_onehot[w_pick_idx] = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (channel_changed || r_pending) w_next = REQ;
            REQ:     if (read_ack) w_next = DIS;
                     else if (w_ack_timeout) w_next = IDLE;
            DIS:     if (w_drop == '0) w_next = EN;
            EN:      w_next = w_pick_vld ? SETTLE : DONE;
            SETTLE:  if (r_settle_cnt <= 8'd1) w_next = EN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_target     <= '0;
            r_enable     <= '0;
            r_pending    <= 1'b0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
            r_read_req   <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_busy       <= 1'b0;
            r_to_err     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_read_req <= (w_next == REQ);
            r_busy     <= (w_next != IDLE);
            r_cfg_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    r_pending <= 1'b0;
                    r_to_cnt  <= '0;
                    if (w_next == REQ) r_to_err <= 1'b0;
                end
                REQ: begin
                    if (read_ack) r_target <= activate_channels[CHANNEL_COUNT-1:0];
                    else          r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_ack_timeout) r_to_err <= 1'b1;
                end
                DIS:     r_enable <= r_enable & ~w_clear;
                EN: begin
                    if (w_pick_vld) begin
                        r_enable     <= r_enable | w_onehot;
                        r_settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE:  r_settle_cnt <= r_settle_cnt - 8'd1;
                default: ;
            endcase
            // Requests during an operation coalesce and are served from IDLE.
            if (r_state != IDLE && channel_changed) r_pending <= 1'b1;
        end
    end

    assign enable_channels     = r_enable;
    assign read_active_channel = r_read_req;
    assign config_done         = r_cfg_done;
    assign sched_busy          = r_busy;
    assign ack_timeout_err     = r_to_err;

endmodule
